// File: rtl/jogo_pkg.sv
// Shared types and defaults for the memory-game blocks.
package jogo_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT = 50000;
   localparam int unsigned N_BOTOES_DEFAULT = 4;
   localparam int unsigned NUM_JOGADAS_W    = 8;

   typedef enum logic [2:0] {
      OCIOSO       = 3'd0,
      FILTRA_PRESS = 3'd1,
      PRESSIONADO  = 3'd2,
      FILTRA_SOLTA = 3'd3,
      INVALIDA     = 3'd4
   } estado_cond_t;

endpackage : jogo_pkg

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-low reset.
module sincronizador_2ff #(
   parameter int unsigned LARGURA = 1
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic [LARGURA-1:0] dado_i,
   output logic [LARGURA-1:0] dado_o
);

   logic [LARGURA-1:0] meta_q;
   logic [LARGURA-1:0] sinc_q;

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         meta_q <= '0;
         sinc_q <= '0;
      end else begin
         meta_q <= dado_i;
         sinc_q <= meta_q;
      end
   end

   assign dado_o = sinc_q;

endmodule : sincronizador_2ff

// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronise, debounce, reject multi-button presses, pulse per play.
// Define CONDICIONADOR_CONTA_JOGADAS_EN to enable the accepted-press counter on db_num_jogadas.
module condicionador_botoes
   import jogo_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned N_BOTOES        = N_BOTOES_DEFAULT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_BOTOES-1:0]      botoes,
   input  logic                     habilita,
   output logic                     jogada_feita,
   output logic [N_BOTOES-1:0]      jogada,
   output logic                     erro_multiplo,
   output logic                     db_tem_jogada,
   output logic [2:0]               db_estado,
   output logic [NUM_JOGADAS_W-1:0] db_num_jogadas
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   estado_cond_t        estado_q, estado_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_BOTOES-1:0] amostra_q, amostra_d;
   logic [N_BOTOES-1:0] jogada_q, jogada_d;
   logic                jogada_feita_q, jogada_feita_d;
   logic                erro_multiplo_q, erro_multiplo_d;
   logic                tem_jogada_q;
   logic [N_BOTOES-1:0] s_botoes;
   logic                um_botao_c;

   sincronizador_2ff #(
      .LARGURA (N_BOTOES)
   ) u_sinc (
      .clock_i (clock),
      .reset_i (reset),
      .dado_i  (botoes),
      .dado_o  (s_botoes)
   );

   // Exactly one bit set: clearing the lowest set bit leaves nothing (amostra is never 0 here).
   assign um_botao_c = ((amostra_q & (amostra_q - N_BOTOES'(1))) == '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q        <= OCIOSO;
         cnt_q           <= '0;
         amostra_q       <= '0;
         jogada_q        <= '0;
         jogada_feita_q  <= 1'b0;
         erro_multiplo_q <= 1'b0;
         tem_jogada_q    <= 1'b0;
      end else begin
         estado_q        <= estado_d;
         cnt_q           <= cnt_d;
         amostra_q       <= amostra_d;
         jogada_q        <= jogada_d;
         jogada_feita_q  <= jogada_feita_d;
         erro_multiplo_q <= erro_multiplo_d;
         tem_jogada_q    <= (estado_d == PRESSIONADO);
      end
   end

   always_comb begin
      estado_d        = estado_q;
      cnt_d           = cnt_q;
      amostra_d       = amostra_q;
      jogada_d        = jogada_q;
      jogada_feita_d  = 1'b0;
      erro_multiplo_d = 1'b0;

      case (estado_q)
         OCIOSO: begin
            if (s_botoes != '0) begin
               amostra_d = s_botoes;
               cnt_d     = '0;
               estado_d  = FILTRA_PRESS;
            end
         end
         FILTRA_PRESS: begin
            if (s_botoes != amostra_q) begin
               cnt_d    = '0;
               estado_d = OCIOSO;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d = '0;
               if (um_botao_c) begin
                  estado_d = PRESSIONADO;
                  if (habilita) begin
                     jogada_d       = amostra_q;
                     jogada_feita_d = 1'b1;
                  end
               end else begin
                  estado_d        = INVALIDA;
                  erro_multiplo_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSIONADO: begin
            if (s_botoes == '0) begin
               cnt_d    = '0;
               estado_d = FILTRA_SOLTA;
            end
         end
         FILTRA_SOLTA: begin
            if (s_botoes != '0) begin
               cnt_d    = '0;
               estado_d = PRESSIONADO;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d    = '0;
               estado_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         INVALIDA: begin
            if (s_botoes == '0) begin
               cnt_d    = '0;
               estado_d = FILTRA_SOLTA;
            end
         end
         default: begin
            cnt_d    = '0;
            estado_d = OCIOSO;
         end
      endcase
   end

   assign jogada_feita  = jogada_feita_q;
   assign jogada        = jogada_q;
   assign erro_multiplo = erro_multiplo_q;
   assign db_tem_jogada = tem_jogada_q;
   assign db_estado     = 3'(estado_q);

`ifdef CONDICIONADOR_CONTA_JOGADAS_EN
   logic [NUM_JOGADAS_W-1:0] num_jogadas_q;

   // Advances on the same edge that raises jogada_feita; wraps naturally.
   always_ff @(posedge clock) begin
      if (!reset) begin
         num_jogadas_q <= '0;
      end else if (jogada_feita_d) begin
         num_jogadas_q <= num_jogadas_q + NUM_JOGADAS_W'(1);
      end
   end

   assign db_num_jogadas = num_jogadas_q;
`else
   assign db_num_jogadas = 8'h00;
`endif

endmodule : condicionador_botoes

// File: tb/tb_condicionador_botoes.sv
// Directed self-checking bench for condicionador_botoes with DEBOUNCE_CYCLES=4.
module tb_condicionador_botoes;

   localparam int unsigned DB = 4;
   localparam int unsigned NB = 4;

`ifdef CONDICIONADOR_CONTA_JOGADAS_EN
   localparam bit CONTA_EN = 1'b1;
`else
   localparam bit CONTA_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [NB-1:0] botoes;
   logic          habilita;
   logic          jogada_feita;
   logic [NB-1:0] jogada;
   logic          erro_multiplo;
   logic          db_tem_jogada;
   logic [2:0]    db_estado;
   logic [7:0]    db_num_jogadas;

   int n_testes = 0;
   int n_falhas = 0;
   int n_ambos  = 0;
   int n_jf, n_erro, tot_jf, tot_erro;
   int esp_num;

   condicionador_botoes #(
      .DEBOUNCE_CYCLES (DB),
      .N_BOTOES        (NB)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .botoes         (botoes),
      .habilita       (habilita),
      .jogada_feita   (jogada_feita),
      .jogada         (jogada),
      .erro_multiplo  (erro_multiplo),
      .db_tem_jogada  (db_tem_jogada),
      .db_estado      (db_estado),
      .db_num_jogadas (db_num_jogadas)
   );

   always #5 clock = ~clock;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_testes++;
      if (obs !== esp) begin
         n_falhas++;
         $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
      end
   endtask

   task automatic passo();
      @(posedge clock);
      #1;
   endtask

   // Advances n cycles, counting the pulses seen.
   task automatic roda(input int n, output int jf, output int er);
      jf = 0;
      er = 0;
      repeat (n) begin
         passo();
         if (jogada_feita) jf++;
         if (erro_multiplo) er++;
         if (jogada_feita && erro_multiplo) n_ambos++;
      end
   endtask

   function automatic logic [31:0] num_esp(input int n);
      return CONTA_EN ? 32'(n % 256) : 32'd0;
   endfunction

   initial begin
      reset    = 1'b0;
      habilita = 1'b1;
      botoes   = 4'b0010;
      esp_num  = 0;

      // Reset held 3 cycles with a button down
      repeat (3) passo();
      verifica("rst_jf",    32'(jogada_feita),   32'd0);
      verifica("rst_jog",   32'(jogada),         32'd0);
      verifica("rst_erro",  32'(erro_multiplo),  32'd0);
      verifica("rst_est",   32'(db_estado),      32'd0);
      verifica("rst_tem",   32'(db_tem_jogada),  32'd0);
      verifica("rst_num",   32'(db_num_jogadas), 32'd0);
      reset = 1'b1;
      repeat (6) passo();
      verifica("rst_k5_jf", 32'(jogada_feita), 32'd0);
      passo();
      esp_num++;
      verifica("rst_k6_jf",  32'(jogada_feita),  32'd1);
      verifica("rst_k6_jog", 32'(jogada),        32'd2);
      verifica("rst_k6_tem", 32'(db_tem_jogada), 32'd1);
      passo();
      verifica("rst_k7_jf",  32'(jogada_feita), 32'd0);
      botoes = 4'b0000;
      roda(10, n_jf, n_erro);
      verifica("rst_sol_jf",  32'(n_jf),      32'd0);
      verifica("rst_sol_est", 32'(db_estado), 32'd0);

      // Clean single press: exact latency and state sequence
      botoes = 4'b0100;
      repeat (2) passo();
      verifica("p_k1_est", 32'(db_estado), 32'd0);
      passo();
      verifica("p_k2_est", 32'(db_estado), 32'd1);
      repeat (3) passo();
      verifica("p_k5_est", 32'(db_estado),    32'd1);
      verifica("p_k5_jf",  32'(jogada_feita), 32'd0);
      passo();
      esp_num++;
      verifica("p_k6_jf",  32'(jogada_feita), 32'd1);
      verifica("p_k6_est", 32'(db_estado),    32'd2);
      verifica("p_k6_jog", 32'(jogada),       32'd4);
      passo();
      verifica("p_k7_jf",  32'(jogada_feita), 32'd0);
      botoes = 4'b0000;
      repeat (2) passo();
      verifica("p_m1_est", 32'(db_estado), 32'd2);
      passo();
      verifica("p_m2_est", 32'(db_estado), 32'd3);
      repeat (3) passo();
      verifica("p_m5_est", 32'(db_estado), 32'd3);
      passo();
      verifica("p_m6_est", 32'(db_estado), 32'd0);
      verifica("p_m6_jog", 32'(jogada),    32'd4);
      verifica("p_num",    32'(db_num_jogadas), num_esp(esp_num));

      // Press bounce, then stable, then release bounce
      tot_jf = 0;
      for (int i = 0; i < 10; i++) begin
         botoes = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         roda(2, n_jf, n_erro);
         tot_jf += n_jf;
      end
      verifica("b_ruido_jf", 32'(tot_jf), 32'd0);
      botoes = 4'b0001;
      roda(12, n_jf, n_erro);
      esp_num++;
      verifica("b_estavel_jf", 32'(n_jf),   32'd1);
      verifica("b_jog",        32'(jogada), 32'd1);
      tot_jf = 0;
      for (int i = 0; i < 10; i++) begin
         botoes = (i % 2 == 0) ? 4'b0000 : 4'b0001;
         roda(2, n_jf, n_erro);
         tot_jf += n_jf;
      end
      botoes = 4'b0000;
      roda(12, n_jf, n_erro);
      tot_jf += n_jf;
      verifica("b_solta_jf",  32'(tot_jf),    32'd0);
      verifica("b_solta_est", 32'(db_estado), 32'd0);

      // Two buttons at once
      botoes = 4'b1001;
      roda(10, n_jf, n_erro);
      verifica("m_erro",   32'(n_erro),        32'd1);
      verifica("m_jf",     32'(n_jf),          32'd0);
      verifica("m_jog",    32'(jogada),        32'd1);
      verifica("m_est",    32'(db_estado),     32'd4);
      verifica("m_tem",    32'(db_tem_jogada), 32'd0);
      botoes = 4'b0000;
      roda(10, n_jf, n_erro);
      verifica("m_sol_erro", 32'(n_erro),    32'd0);
      verifica("m_sol_est",  32'(db_estado), 32'd0);

      // Plays disabled: press filtered, no pulse, jogada kept
      habilita = 1'b0;
      botoes   = 4'b1000;
      roda(10, n_jf, n_erro);
      verifica("h0_jf",  32'(n_jf),          32'd0);
      verifica("h0_jog", 32'(jogada),        32'd1);
      verifica("h0_est", 32'(db_estado),     32'd2);
      verifica("h0_tem", 32'(db_tem_jogada), 32'd1);
      botoes = 4'b0000;
      roda(10, n_jf, n_erro);
      habilita = 1'b1;
      botoes   = 4'b1000;
      roda(10, n_jf, n_erro);
      esp_num++;
      verifica("h1_jf",  32'(n_jf),   32'd1);
      verifica("h1_jog", 32'(jogada), 32'd8);
      botoes = 4'b0000;
      roda(10, n_jf, n_erro);
      verifica("h1_num", 32'(db_num_jogadas), num_esp(esp_num));

      // Counter wrap: 257 presses from reset
      reset = 1'b0;
      repeat (2) passo();
      reset = 1'b1;
      verifica("c_rst_num", 32'(db_num_jogadas), 32'd0);
      tot_jf   = 0;
      tot_erro = 0;
      for (int i = 0; i < 257; i++) begin
         botoes = 4'(1 << (i % 4));
         roda(9, n_jf, n_erro);
         tot_jf   += n_jf;
         tot_erro += n_erro;
         botoes = 4'b0000;
         roda(9, n_jf, n_erro);
         tot_jf   += n_jf;
         tot_erro += n_erro;
      end
      verifica("c_jf",   32'(tot_jf),         32'd257);
      verifica("c_erro", 32'(tot_erro),       32'd0);
      verifica("c_num",  32'(db_num_jogadas), num_esp(257));
      verifica("ambos",  32'(n_ambos),        32'd0);

      $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
      $finish;
   end

endmodule : tb_condicionador_botoes
